// File: rtl/leaf_user_fifo_if.sv
// Handshake bundle between the leaf interface user port, the elastic buffer
// and the user core; the buffer sits on the slave modport.
interface leaf_user_fifo_if #(
    parameter int PAYLOAD_BITS = 32
);
    logic [PAYLOAD_BITS-1:0] din;
    logic                    val_in;
    logic                    ready_upward;
    logic [PAYLOAD_BITS-1:0] dout;
    logic                    val_out;
    logic                    ready_downward;
    logic                    almost_full;

    modport master (
        output din, val_in, ready_downward,
        input  ready_upward, dout, val_out, almost_full
    );

    modport slave (
        input  din, val_in, ready_downward,
        output ready_upward, dout, val_out, almost_full
    );
endinterface

// File: rtl/leaf_user_fifo.sv
// Elastic buffer in the user clock domain between the leaf interface and a stalling core.
// Optional LEAF_FIFO_LEVEL_EN exposes the registered occupancy on the level port.
module leaf_user_fifo #(
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_BITS   = 4,
    parameter int AFULL_LEVEL  = 12
) (
    input logic             clk_user,
    input logic             reset,
    leaf_user_fifo_if.slave bus
`ifdef LEAF_FIFO_LEVEL_EN
    ,
    output logic [DEPTH_BITS:0] level
`endif
);
    localparam int                  DEPTH    = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] CAPACITY = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] AFULL    = (DEPTH_BITS + 1)'(AFULL_LEVEL);
    localparam logic [DEPTH_BITS:0] OCC_ONE  = (DEPTH_BITS + 1)'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);

    logic [PAYLOAD_BITS-1:0] mem [DEPTH];
    logic [DEPTH_BITS-1:0]   wr_ptr;
    logic [DEPTH_BITS-1:0]   rd_ptr;
    logic [DEPTH_BITS-1:0]   rd_ptr_next;
    logic [DEPTH_BITS:0]     occupancy;
    logic [DEPTH_BITS:0]     occupancy_next;
    logic [PAYLOAD_BITS-1:0] dout_next;
    logic                    do_write;
    logic                    do_read;

    assign do_write = bus.val_in && bus.ready_upward;
    assign do_read  = bus.val_out && bus.ready_downward;

    // dout is registered from the word that will be oldest after this edge; when
    // that word is the one being written right now it comes straight from din.
    always_comb begin
        rd_ptr_next    = do_read ? rd_ptr + PTR_ONE : rd_ptr;
        occupancy_next = occupancy;
        if (do_write && !do_read) begin
            occupancy_next = occupancy + OCC_ONE;
        end else if (!do_write && do_read) begin
            occupancy_next = occupancy - OCC_ONE;
        end
        dout_next = bus.dout;
        if (occupancy_next != '0) begin
            if (do_write && (rd_ptr_next == wr_ptr)) begin
                dout_next = bus.din;
            end else begin
                dout_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk_user) begin
        if (do_write) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk_user or posedge reset) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            occupancy        <= '0;
            bus.ready_upward <= 1'b0;
            bus.val_out      <= 1'b0;
            bus.almost_full  <= 1'b0;
            bus.dout         <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr           <= rd_ptr_next;
            occupancy        <= occupancy_next;
            bus.ready_upward <= (occupancy_next < CAPACITY);
            bus.val_out      <= (occupancy_next != '0);
            bus.almost_full  <= (occupancy_next >= AFULL);
            bus.dout         <= dout_next;
        end
    end

`ifdef LEAF_FIFO_LEVEL_EN
    assign level = occupancy;
`endif
endmodule

// File: tb/tb_leaf_user_fifo.sv
// Randomised and directed bench for leaf_user_fifo against a queue-based model
// of a 16-word in-order buffer with almost-full at 12.
module tb_leaf_user_fifo;
    localparam int PB  = 32;
    localparam int DB  = 4;
    localparam int AF  = 12;
    localparam int CAP = 16;

    logic clk_user = 1'b0;
    logic reset    = 1'b1;
    int   checks   = 0;
    int   errors   = 0;

    logic [PB-1:0] q[$];
    bit            rst_hold;
    bit            last_w;
    bit            last_r;

    always #5 clk_user = ~clk_user;

    leaf_user_fifo_if #(.PAYLOAD_BITS(PB)) bus ();

`ifdef LEAF_FIFO_LEVEL_EN
    logic [DB:0] level;
`endif

    leaf_user_fifo #(
        .PAYLOAD_BITS(PB),
        .DEPTH_BITS  (DB),
        .AFULL_LEVEL (AF)
    ) dut (
        .clk_user(clk_user),
        .reset   (reset),
        .bus     (bus)
`ifdef LEAF_FIFO_LEVEL_EN
        ,
        .level   (level)
`endif
    );

    function automatic bit model_ready();
        return !rst_hold && (q.size() < CAP);
    endfunction

    function automatic bit model_val();
        return q.size() != 0;
    endfunction

    // Drives one cycle of inputs, lets the edge happen and advances the model.
    task automatic drive_edge(input bit v, input logic [PB-1:0] d, input bit r);
        bit w;
        bit rd;
        bus.val_in         = v;
        bus.din            = d;
        bus.ready_downward = r;
        w  = v && model_ready();
        rd = r && model_val();
        @(posedge clk_user);
        if (rd) void'(q.pop_front());
        if (w) q.push_back(d);
        rst_hold = 0;
        last_w   = w;
        last_r   = rd;
        @(negedge clk_user);
    endtask

    task automatic test_reset();
        bus.val_in = 0;
        bus.din = '0;
        bus.ready_downward = 0;
        reset = 1;
        q.delete();
        rst_hold = 1;
        @(negedge clk_user);
        checks++; if (bus.ready_upward !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.ready_upward); end
        checks++; if (bus.val_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_val_out: got %b expected 0", bus.val_out); end
        checks++; if (bus.dout !== '0) begin errors++; $display("[TB] FAIL reset_dout: got %h expected 0", bus.dout); end
        checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_afull: got %b expected 0", bus.almost_full); end
`ifdef LEAF_FIFO_LEVEL_EN
        checks++; if (level !== '0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
`endif
        #2 reset = 0;
        #1;
        checks++; if (bus.ready_upward !== 1'b0) begin errors++; $display("[TB] FAIL release_ready: got %b expected 0", bus.ready_upward); end
        drive_edge(0, '0, 0);
        checks++; if (bus.ready_upward !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b expected 1", bus.ready_upward); end
        checks++; if (bus.val_out !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_val: got %b expected 0", bus.val_out); end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 32; i++) begin
            checks++; if (bus.ready_upward !== 1'b1) begin errors++; $display("[TB] FAIL stream_ready[%0d]: got %b expected 1", i, bus.ready_upward); end
            drive_edge(1, PB'(i), 1);
            checks++; if (bus.val_out !== 1'b1) begin errors++; $display("[TB] FAIL stream_val[%0d]: got %b expected 1", i, bus.val_out); end
            checks++; if (bus.dout !== PB'(i)) begin errors++; $display("[TB] FAIL stream_dout[%0d]: got %h expected %h", i, bus.dout, PB'(i)); end
`ifdef LEAF_FIFO_LEVEL_EN
            checks++; if (level > 1) begin errors++; $display("[TB] FAIL stream_level[%0d]: got %0d expected <=1", i, level); end
`endif
        end
        drive_edge(0, '0, 1);
        checks++; if (bus.val_out !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain: got %b expected 0", bus.val_out); end
    endtask

    task automatic test_fill();
        int accepted = 0;
        for (int c = 0; c < 20; c++) begin
            checks++; if (bus.ready_upward !== model_ready()) begin errors++; $display("[TB] FAIL fill_ready[%0d]: got %b expected %b", c, bus.ready_upward, model_ready()); end
            if (bus.ready_upward === 1'b1) accepted++;
            drive_edge(1, 32'h1000 + PB'(accepted - (bus.ready_upward === 1'b1 ? 1 : 0)), 0);
            checks++; if (bus.almost_full !== (q.size() >= AF)) begin errors++; $display("[TB] FAIL fill_afull[%0d]: got %b expected %b", c, bus.almost_full, q.size() >= AF); end
        end
        checks++; if (accepted != CAP) begin errors++; $display("[TB] FAIL fill_accepted: got %0d expected %0d", accepted, CAP); end
        checks++; if (bus.ready_upward !== 1'b0) begin errors++; $display("[TB] FAIL fill_ready_full: got %b expected 0", bus.ready_upward); end
        checks++; if (bus.almost_full !== 1'b1) begin errors++; $display("[TB] FAIL fill_afull_full: got %b expected 1", bus.almost_full); end
`ifdef LEAF_FIFO_LEVEL_EN
        checks++; if (level !== 5'd16) begin errors++; $display("[TB] FAIL fill_level: got %0d expected 16", level); end
`endif
    endtask

    task automatic test_full_rw();
        checks++; if (bus.dout !== 32'h1000) begin errors++; $display("[TB] FAIL full_oldest: got %h expected 00001000", bus.dout); end
        drive_edge(1, 32'h1010, 1);
        checks++; if (bus.ready_upward !== 1'b1) begin errors++; $display("[TB] FAIL full_rw_ready: got %b expected 1", bus.ready_upward); end
        checks++; if (bus.dout !== 32'h1001) begin errors++; $display("[TB] FAIL full_rw_dout: got %h expected 00001001", bus.dout); end
`ifdef LEAF_FIFO_LEVEL_EN
        checks++; if (level !== 5'd15) begin errors++; $display("[TB] FAIL full_rw_level: got %0d expected 15", level); end
`endif
        drive_edge(1, 32'h1010, 0);
        checks++; if (bus.ready_upward !== 1'b0) begin errors++; $display("[TB] FAIL refill_ready: got %b expected 0", bus.ready_upward); end
        checks++; if (bus.almost_full !== 1'b1) begin errors++; $display("[TB] FAIL refill_afull: got %b expected 1", bus.almost_full); end
`ifdef LEAF_FIFO_LEVEL_EN
        checks++; if (level !== 5'd16) begin errors++; $display("[TB] FAIL refill_level: got %0d expected 16", level); end
`endif
        for (int k = 1; k <= 16; k++) begin
            checks++; if (bus.dout !== 32'h1000 + PB'(k)) begin errors++; $display("[TB] FAIL full_drain[%0d]: got %h expected %h", k, bus.dout, 32'h1000 + PB'(k)); end
            drive_edge(0, '0, 1);
        end
        checks++; if (bus.val_out !== 1'b0) begin errors++; $display("[TB] FAIL full_drain_empty: got %b expected 0", bus.val_out); end
    endtask

    task automatic test_wrap();
        logic [PB-1:0] wdata    = 32'h2000;
        logic [PB-1:0] exp_next = 32'h2000;
        bit v;
        bit r;
        for (int c = 0; c < 140; c++) begin
            v = (c < 100) ? ($urandom_range(0, 1) == 1) : 1'b0;
            r = (c < 100) ? ($urandom_range(0, 1) == 1) : 1'b1;
            checks++; if (bus.val_out !== model_val()) begin errors++; $display("[TB] FAIL wrap_val[%0d]: got %b expected %b", c, bus.val_out, model_val()); end
            checks++; if (bus.ready_upward !== model_ready()) begin errors++; $display("[TB] FAIL wrap_ready[%0d]: got %b expected %b", c, bus.ready_upward, model_ready()); end
            checks++; if (bus.almost_full !== (q.size() >= AF)) begin errors++; $display("[TB] FAIL wrap_afull[%0d]: got %b expected %b", c, bus.almost_full, q.size() >= AF); end
            if (bus.val_out === 1'b1 && r) begin
                checks++; if (bus.dout !== exp_next) begin errors++; $display("[TB] FAIL wrap_order[%0d]: got %h expected %h", c, bus.dout, exp_next); end
                exp_next++;
            end
            drive_edge(v, wdata, r);
            if (last_w) wdata++;
        end
        checks++; if (exp_next !== wdata) begin errors++; $display("[TB] FAIL wrap_count: got %h expected %h", exp_next, wdata); end
        checks++; if (bus.val_out !== 1'b0) begin errors++; $display("[TB] FAIL wrap_empty: got %b expected 0", bus.val_out); end
    endtask

    task automatic test_empty_write();
        bus.val_in = 1;
        bus.din = 32'hDEADBEEF;
        bus.ready_downward = 0;
        #1;
        checks++; if (bus.val_out !== 1'b0) begin errors++; $display("[TB] FAIL empty_wr_before: got %b expected 0", bus.val_out); end
        drive_edge(1, 32'hDEADBEEF, 0);
        checks++; if (bus.val_out !== 1'b1) begin errors++; $display("[TB] FAIL empty_wr_val: got %b expected 1", bus.val_out); end
        checks++; if (bus.dout !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL empty_wr_dout: got %h expected deadbeef", bus.dout); end
        drive_edge(0, '0, 1);
        checks++; if (bus.val_out !== 1'b0) begin errors++; $display("[TB] FAIL empty_wr_drain: got %b expected 0", bus.val_out); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) drive_edge(1, 32'h3000 + PB'(i), 0);
        checks++; if (bus.val_out !== 1'b1) begin errors++; $display("[TB] FAIL mid_val_before: got %b expected 1", bus.val_out); end
        #2 reset = 1;
        #1;
        q.delete();
        rst_hold = 1;
        checks++; if (bus.val_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_val: got %b expected 0", bus.val_out); end
        checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("[TB] FAIL mid_afull: got %b expected 0", bus.almost_full); end
        checks++; if (bus.ready_upward !== 1'b0) begin errors++; $display("[TB] FAIL mid_ready: got %b expected 0", bus.ready_upward); end
`ifdef LEAF_FIFO_LEVEL_EN
        checks++; if (level !== '0) begin errors++; $display("[TB] FAIL mid_level: got %0d expected 0", level); end
`endif
        #1 reset = 0;
        drive_edge(1, 32'hA5A5A5A5, 0);
        checks++; if (bus.ready_upward !== 1'b1) begin errors++; $display("[TB] FAIL mid_rel_ready: got %b expected 1", bus.ready_upward); end
        checks++; if (bus.val_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_rel_val: got %b expected 0", bus.val_out); end
        drive_edge(1, 32'hA5A5A5A5, 0);
        checks++; if (bus.dout !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL mid_first_word: got %h expected a5a5a5a5", bus.dout); end
        drive_edge(0, '0, 1);
        checks++; if (bus.val_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_stale: got %b expected 0", bus.val_out); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_full_rw();
        test_wrap();
        test_empty_write();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end
endmodule

// File: doc/leaf_user_fifo.md
# leaf_user_fifo

Elastic buffer between a leaf interface's user-side output port and the user core's input port, in the user clock domain. It decouples the interface's valid/ack stream from a core that stalls, such as a soft CPU polling its input. It holds up to 2^DEPTH_BITS payload words in order, exposes an almost-full flag for flow monitoring, and never drops or duplicates a word.

## Interface
- PAYLOAD_BITS, 32, payload word width (matches leaf interface PAYLOAD_BITS)
- DEPTH_BITS, 4, log2 of capacity; capacity = 2^DEPTH_BITS words (16), legal range 1..10
- AFULL_LEVEL, 12, occupancy at or above which almost_full asserts; legal 1..2^DEPTH_BITS
- clk_user  in  1  user clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- din  in  PAYLOAD_BITS  word from leaf interface (dout_leaf_interface2user)
- val_in  in  1  din valid
- ready_upward  out  1  buffer can accept a word this cycle
- dout  out  PAYLOAD_BITS  word to user core
- val_out  out  1  dout valid
- ready_downward  in  1  user core accepts dout this cycle
- almost_full  out  1  occupancy >= AFULL_LEVEL
- level  out  DEPTH_BITS+1  current occupancy, present only with LEAF_FIFO_LEVEL_EN

## Operation
- Write transfer: val_in && ready_upward on a rising edge. Read transfer: val_out && ready_downward on a rising edge.
- ready_upward = (occupancy < 2^DEPTH_BITS). It is a pure function of registered state, with no combinational path from ready_downward. Full with a simultaneous read still refuses the write.
- val_out = (occupancy != 0). dout is the oldest stored word and stays stable while val_out && !ready_downward.
- Occupancy update per cycle: +1 on write only, -1 on read only, unchanged on both or neither. Occupancy width is DEPTH_BITS+1.
- Read/write pointers are DEPTH_BITS wide and wrap modulo 2^DEPTH_BITS without special casing.
- Empty with a simultaneous write: no same-cycle bypass. The word appears on dout the next cycle.
- val_in is ignored while ready_upward is low. Upstream holds the word, per the leaf interface vld/ack contract.
- almost_full is registered from next-state occupancy, so it is exact in the same cycle as occupancy.
- Reset mid-operation discards all stored words immediately (asynchronous). Pointers and occupancy go to 0.

## Timing
- Reset values: ready_upward=0 while reset is asserted, 1 from the first edge after deassertion. val_out=0, dout=0, almost_full=0, level=0.
- Latency: write accepted at edge N gives val_out=1 after edge N (visible in cycle N+1).
- Throughput: one write and one read per cycle sustained at any occupancy strictly between 0 and full.
- Full to not-full: a read at edge N raises ready_upward after edge N. The earliest refill write is at edge N+1.
- All outputs come from registers, or from the storage read of a registered pointer. There are no input-to-output combinational paths.

## Configuration
- LEAF_FIFO_LEVEL_EN defined: the level port exists and is driven with the registered occupancy (0..2^DEPTH_BITS).
- LEAF_FIFO_LEVEL_EN undefined: the level port is absent and occupancy stays internal. All other behaviour is identical.

## Test plan
- Reset then stream: deassert reset, hold ready_downward=1, write 0x00000001..0x00000020 back-to-back. Expect dout to equal the same sequence, each word one cycle after its write. ready_upward stays 1 and level never exceeds 1.
- Fill to full: ready_downward=0, offer 20 words. Expect exactly 16 accepted and ready_upward=0 after the 16th. almost_full rises after the 12th accept and level=16. Offered words 17..20 are held upstream, not lost.
- Full plus simultaneous read/write: at level=16 assert ready_downward=1 and val_in=1 for one cycle. Expect the read to occur, the write to be refused, and level=15. The next cycle's write is accepted and level=16.
- Wrap-around: run 100 random-stall cycles (50% val_in, 50% ready_downward) with incrementing data. The scoreboard sees an in-order, gap-free sequence across multiple pointer wraps.
- Empty with a simultaneous write: level=0 and a write of 0xDEADBEEF at edge N. val_out must be 0 during cycle N and 1 with dout=0xDEADBEEF in cycle N+1.
- Reset mid-operation: at level=7, pulse reset asynchronously between edges. val_out, almost_full and level go to 0 immediately. After release, the first written word 0xA5A5A5A5 is the first read, with no stale data.
